// File: rtl/soc_system_pio_in_dbnc.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_in_dbnc
// Brief    : Avalon-MM input PIO with per-bit sync, debounce and edge IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_pio_in_dbnc #(
    parameter int               WIDTH           = 10,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_RISE_EN   = '1,
    parameter logic [WIDTH-1:0] RESET_FALL_EN   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [c_CNT_W-1:0]                r_cnt     [WIDTH];
    logic [c_CNT_W-1:0]                w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0]                  w_sync;
    logic [WIDTH-1:0]                  w_deb_nxt;
    logic [WIDTH-1:0]                  w_cnt_nz;
    logic [WIDTH-1:0]                  r_deb;
    logic [WIDTH-1:0]                  r_deb_d;
    logic [WIDTH-1:0]                  r_irq_mask;
    logic [WIDTH-1:0]                  r_edge_capture;
    logic [WIDTH-1:0]                  r_rise_en;
    logic [WIDTH-1:0]                  r_fall_en;
    logic [WIDTH-1:0]                  w_edge;
    logic [WIDTH-1:0]                  w_clr;
    logic [WIDTH-1:0]                  w_wdata;
    logic [31:0]                       w_rd;
    logic                              w_wr;
    logic                              w_busy;
    logic                              r_irq;
    logic                              w_unused_wdata;

    assign w_sync         = r_sync[SYNC_STAGES-1];
    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;
    assign w_busy         = |w_cnt_nz;

    // Counter restarts whenever the synchronised input agrees with the debounced value.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_dbnc
            logic w_diff;
            logic w_hit;
            assign w_diff       = w_sync[i] ^ r_deb[i];
            assign w_hit        = (r_cnt[i] == c_CNT_MAX);
            assign w_cnt_nxt[i] = (!w_diff || w_hit) ? '0 : r_cnt[i] + c_CNT_W'(1);
            assign w_deb_nxt[i] = (w_diff && w_hit) ? w_sync[i] : r_deb[i];
            assign w_cnt_nz[i]  = |r_cnt[i];
        end
    endgenerate

    assign w_edge = (r_deb & ~r_deb_d & r_rise_en) | (~r_deb & r_deb_d & r_fall_en);
    assign w_clr  = (w_wr && address == 3'd3) ? w_wdata : '0;

    always_comb begin
        w_rd = '0;
        case (address)
            3'd0:    w_rd[WIDTH-1:0] = r_deb;
            3'd1:    w_rd[WIDTH-1:0] = w_sync;
            3'd2:    w_rd[WIDTH-1:0] = r_irq_mask;
            3'd3:    w_rd[WIDTH-1:0] = r_edge_capture;
            3'd4:    w_rd[WIDTH-1:0] = r_rise_en;
            3'd5:    w_rd[WIDTH-1:0] = r_fall_en;
            3'd6:    w_rd[1:0]       = {w_busy, r_irq};
            default: w_rd            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync         <= '0;
            r_deb          <= '0;
            r_deb_d        <= '0;
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
            r_rise_en      <= RESET_RISE_EN;
            r_fall_en      <= RESET_FALL_EN;
            r_irq          <= 1'b0;
            readdata       <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_cnt    <= w_cnt_nxt;
            r_deb    <= w_deb_nxt;
            r_deb_d  <= r_deb;
            readdata <= w_rd;
            // A new edge wins over a same-cycle clear so no event is lost.
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
            r_irq          <= |(r_edge_capture & r_irq_mask);
            if (w_wr && address == 3'd2) r_irq_mask <= w_wdata;
            if (w_wr && address == 3'd4) r_rise_en  <= w_wdata;
            if (w_wr && address == 3'd5) r_fall_en  <= w_wdata;
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_in_dbnc.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_pio_in_dbnc
// Brief    : Directed self-checking bench for soc_system_pio_in_dbnc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_system_pio_in_dbnc;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    soc_system_pio_in_dbnc #(
        .WIDTH           (10),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_RISE_EN   (10'h3FF),
        .RESET_FALL_EN   (10'h3FF)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    logic [31:0] d;
    logic [31:0] exp_rst [8];
    logic        busy_seen;

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset values of every register
        exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3FF, 32'h3FF, 32'h0, 32'h0};
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            chk($sformatf("reset_addr%0d", a), d, exp_rst[a]);
        end
        chk("reset_irq", {31'b0, irq}, 32'h0);

        // Rising edge on bit 0: capture lands exactly 2+4+1 edges after the change
        address    = 3'd3;
        in_port[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) chk("t2_cap_edge7", readdata, 32'h0);
            if (k == 8) chk("t2_cap_edge8", readdata, 32'h1);
        end
        rd(3'd0, d); chk("t2_data", d, 32'h001);
        rd(3'd1, d); chk("t2_raw", d, 32'h001);
        chk("t2_irq_masked", {31'b0, irq}, 32'h0);
        wr(3'd3, 32'h001);
        rd(3'd3, d); chk("t2_cap_cleared", d, 32'h0);

        // Bounce on bit 3: counter activity but no capture until stable
        busy_seen = 1'b0;
        address   = 3'd6;
        for (int k = 0; k < 20; k++) begin
            in_port[3] = ((k / 2) % 2 == 0);
            tick();
            if (readdata[1]) busy_seen = 1'b1;
        end
        chk("t3_busy_seen", {31'b0, busy_seen}, 32'h1);
        address    = 3'd0;
        in_port[3] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) chk("t3_data_edge6", readdata, 32'h001);
            if (k == 7) chk("t3_data_edge7", readdata, 32'h009);
        end
        rd(3'd3, d); chk("t3_single_capture", d, 32'h008);
        wr(3'd3, 32'h008);

        // Fall-only capture on bit 5 with IRQ, then W1C
        wr(3'd4, 32'h000);
        wr(3'd5, 32'h020);
        wr(3'd2, 32'h020);
        in_port[5] = 1'b1;
        repeat (10) tick();
        rd(3'd3, d); chk("t4_no_rise_cap", d, 32'h0);
        rd(3'd0, d); chk("t4_data_high", d, 32'h029);
        in_port[5] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) chk("t4_irq_edge7", {31'b0, irq}, 32'h0);
            if (k == 8) chk("t4_irq_edge8", {31'b0, irq}, 32'h1);
        end
        rd(3'd3, d); chk("t4_fall_cap", d, 32'h020);
        wr(3'd3, 32'h020);
        chk("t4_irq_after_w1c", {31'b0, irq}, 32'h1);
        tick();
        chk("t4_irq_cleared", {31'b0, irq}, 32'h0);

        // W1C colliding with a new edge on bit 1: set wins
        wr(3'd4, 32'h3FF);
        wr(3'd5, 32'h3FF);
        wr(3'd2, 32'h002);
        in_port[1] = 1'b1;
        repeat (10) tick();
        chk("t5_irq_rise", {31'b0, irq}, 32'h1);
        in_port[1] = 1'b0;
        repeat (6) tick();
        wr(3'd3, 32'h002);
        tick();
        chk("t5_irq_kept", {31'b0, irq}, 32'h1);
        rd(3'd3, d); chk("t5_cap_kept", d, 32'h002);

        // Reset in the middle of a debounce on bit 7
        address    = 3'd6;
        in_port[7] = 1'b1;
        repeat (4) tick();
        chk("t6_status_mid", readdata, 32'h3);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        address = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) chk("t6_data_cleared", readdata, 32'h0);
            if (k == 6) chk("t6_data_edge6", readdata, 32'h0);
            if (k == 7) chk("t6_data_edge7", readdata, 32'h089);
        end
        rd(3'd3, d); chk("t6_cap_after_reset", d, 32'h089);
        rd(3'd2, d); chk("t6_mask_reset", d, 32'h0);
        chk("t6_irq", {31'b0, irq}, 32'h0);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, d); chk("t6_reserved", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
